// File: rtl/l2_msg_pkg.sv
// Shared types for the L1-to-L2 message queue: L2 command encoding, message layout, drain states.
package l2_msg_pkg;

   localparam int unsigned L2_ADDR_W = 26;

   typedef enum logic [1:0] {
      GETLINE        = 2'd0,
      SENDLINE       = 2'd1,
      INVALIDATELINE = 2'd2,
      EVICTLINE      = 2'd3
   } l2_cmd_t;

   typedef struct packed {
      l2_cmd_t                cmd;
      logic [L2_ADDR_W-1:0]   addr;
   } l2_msg_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } drain_state_t;

endpackage

// File: rtl/l2_msg_fifo.sv
// Registered message FIFO: a push at edge N is on rdat_o/rvld_o after edge N (no bypass).
// Caller must not push when full without popping, and must not pop when empty.
module l2_msg_fifo
   import l2_msg_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   push_i,
   input  l2_msg_t                wdat_i,
   input  logic                   pop_i,
   output logic                   rvld_o,
   output l2_msg_t                rdat_o,
   output logic                   full_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   l2_msg_t         mem_q [DEPTH];
   logic [PW-1:0]   head_q, head_d;
   logic [PW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;
   logic            rvld_q;
   l2_msg_t         rdat_q, rdat_d;

   assign head_d = pop_i  ? head_q + PW'(1) : head_q;
   assign tail_d = push_i ? tail_q + PW'(1) : tail_q;

   always_comb begin
      count_d = count_q;
      if (push_i && !pop_i) begin
         count_d = count_q + CW'(1);
      end else if (!push_i && pop_i) begin
         count_d = count_q - CW'(1);
      end
   end

   // Next head comes from the write port when the new head slot is the one being written this edge.
   always_comb begin
      rdat_d = rdat_q;
      if (count_d != '0) begin
         if (push_i && (tail_q == head_d)) begin
            rdat_d = wdat_i;
         end else begin
            rdat_d = mem_q[head_d];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[tail_q] <= wdat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         rvld_q  <= 1'b0;
         rdat_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         rvld_q  <= (count_d != '0);
         rdat_q  <= rdat_d;
      end
   end

   assign rvld_o  = rvld_q;
   assign rdat_o  = rdat_q;
   assign count_o = count_q;
   assign full_o  = (count_q == FULL_CNT);

endmodule

// File: rtl/l2_msg_queue.sv
// Buffers controller-to-L2 messages; push visible on l2_valid one cycle later, 1 msg/cycle sustained.
// Overflowing pushes are dropped (sticky overflow); L2Q_STATS_EN adds per-command/drop counters.
module l2_msg_queue
   import l2_msg_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned CNT_W = 32
) (
   input  logic                   Clock,
   input  logic                   clear,
   input  logic                   in_valid,
   input  logic [1:0]             in_cmd,
   input  logic [L2_ADDR_W-1:0]   in_addr,
   output logic                   in_ready,
   output logic                   l2_valid,
   output logic [1:0]             l2_cmd,
   output logic [L2_ADDR_W-1:0]   l2_addr,
   input  logic                   l2_ready,
   input  logic                   Finish,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   drained
);

   if ((DEPTH < 2) || (DEPTH > 64) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("l2_msg_queue: DEPTH must be a power of two in 2..64");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("l2_msg_queue: CNT_W must be at least 1");
   end

   logic          push, pop, drop, full, to_done;
   l2_msg_t       wr_msg, rd_msg;
   drain_state_t  state_q;
   logic          drained_q;
   logic          overflow_q;

   // A pop in the same cycle frees a slot, so a full queue can still take a message.
   assign in_ready = !full || l2_ready;
   assign push     = in_valid && in_ready;
   assign pop      = l2_valid && l2_ready;
   assign drop     = in_valid && !in_ready;
   assign wr_msg   = '{cmd: l2_cmd_t'(in_cmd), addr: in_addr};

   l2_msg_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (Clock),
      .rst_n_i (clear),
      .push_i  (push),
      .wdat_i  (wr_msg),
      .pop_i   (pop),
      .rvld_o  (l2_valid),
      .rdat_o  (rd_msg),
      .full_o  (full),
      .count_o (count)
   );

   assign l2_cmd  = rd_msg.cmd;
   assign l2_addr = rd_msg.addr;

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         overflow_q <= 1'b0;
      end else if (drop) begin
         overflow_q <= 1'b1;
      end
   end

   // A push landing in the same edge keeps FLUSH, so DONE always means truly empty.
   assign to_done = (state_q == FLUSH) && (count == '0) && !push;

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q   <= IDLE;
         drained_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Finish) begin
                  state_q <= FLUSH;
               end
            end
            FLUSH: begin
               if (to_done) begin
                  state_q   <= DONE;
                  drained_q <= 1'b1;
               end
            end
            DONE: begin
               if (push) begin
                  state_q   <= FLUSH;
                  drained_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= IDLE;
               drained_q <= 1'b0;
            end
         endcase
      end
   end

   assign overflow = overflow_q;
   assign drained  = drained_q;

`ifdef L2Q_STATS_EN
   logic [CNT_W-1:0] cmd_cnt_q [4];
   logic [CNT_W-1:0] drop_cnt_q;
   logic             reported_q;

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < 4; i++) begin
            cmd_cnt_q[i] <= '0;
         end
         drop_cnt_q <= '0;
         reported_q <= 1'b0;
      end else begin
         if (push && (cmd_cnt_q[in_cmd] != '1)) begin
            cmd_cnt_q[in_cmd] <= cmd_cnt_q[in_cmd] + CNT_W'(1);
         end
         if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
         end
         if (to_done) begin
            reported_q <= 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   always @(posedge Clock) begin
      if (clear && to_done && !reported_q) begin
         $display("l2_msg_queue stats: GETLINE=%0d SENDLINE=%0d INVALIDATELINE=%0d EVICTLINE=%0d dropped=%0d",
                  cmd_cnt_q[0], cmd_cnt_q[1], cmd_cnt_q[2], cmd_cnt_q[3], drop_cnt_q);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_l2_msg_queue.sv
// Bench for l2_msg_queue: random and directed traffic against a queue-based reference model.
module tb_l2_msg_queue;

   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          Clock = 1'b0;
   logic          clear;
   logic          in_valid;
   logic [1:0]    in_cmd;
   logic [25:0]   in_addr;
   logic          in_ready;
   logic          l2_valid;
   logic [1:0]    l2_cmd;
   logic [25:0]   l2_addr;
   logic          l2_ready;
   logic          Finish;
   logic [CW-1:0] count;
   logic          overflow;
   logic          drained;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue contents, delivered messages, sticky flags.
   logic [27:0] mq[$];
   logic [27:0] exp_out[$];
   logic [27:0] obs_out[$];
   bit          m_ovf;
   bit          m_flush;
   bit          m_done;

   l2_msg_queue #(.DEPTH(DEPTH), .CNT_W(32)) dut (
      .Clock    (Clock),
      .clear    (clear),
      .in_valid (in_valid),
      .in_cmd   (in_cmd),
      .in_addr  (in_addr),
      .in_ready (in_ready),
      .l2_valid (l2_valid),
      .l2_cmd   (l2_cmd),
      .l2_addr  (l2_addr),
      .l2_ready (l2_ready),
      .Finish   (Finish),
      .count    (count),
      .overflow (overflow),
      .drained  (drained)
   );

   always #5 Clock = ~Clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      mq.delete();
      exp_out.delete();
      obs_out.delete();
      m_ovf   = 1'b0;
      m_flush = 1'b0;
      m_done  = 1'b0;
   endtask

   // One clock: inputs already driven; advances the model with the pre-edge view.
   task automatic step();
      bit rdy, psh, pp, emp;
      #2;
      emp = (mq.size() == 0);
      rdy = (mq.size() < DEPTH) || l2_ready;
      psh = in_valid && rdy;
      pp  = !emp && l2_ready;
      if (l2_valid && l2_ready) obs_out.push_back({l2_cmd, l2_addr});
      @(posedge Clock);
      if (m_done) begin
         if (psh) m_done = 1'b0;
      end else if (m_flush && emp && !psh) begin
         m_done = 1'b1;
      end
      if (Finish) m_flush = 1'b1;
      if (pp) exp_out.push_back(mq.pop_front());
      if (psh) mq.push_back({in_cmd, in_addr});
      if (in_valid && !rdy) m_ovf = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      l2_ready = 1'b0;
      Finish   = 1'b0;
      in_cmd   = 2'd0;
      in_addr  = 26'd0;
      @(negedge Clock);
      clear = 1'b0;
      #2;
      clear = 1'b1;
      model_clear();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      clear = 1'b1;
      #1;
      clear = 1'b0;
      #1;
      checks++; if (l2_valid !== 1'b0) $display("FAIL reset_l2_valid: got %b want 0", l2_valid);
      if (l2_valid !== 1'b0) failures++;
      checks++; if (l2_cmd !== 2'd0) begin failures++; $display("FAIL reset_l2_cmd: got %0d want 0", l2_cmd); end
      checks++; if (l2_addr !== 26'd0) begin failures++; $display("FAIL reset_l2_addr: got %h want 0", l2_addr); end
      checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      checks++; if (drained !== 1'b0) begin failures++; $display("FAIL reset_drained: got %b want 0", drained); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      @(negedge Clock);
      clear = 1'b1;
      model_clear();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_single();
      do_reset();
      in_valid = 1'b1;
      in_cmd   = 2'd1;
      in_addr  = 26'h0ABCDE;
      step();
      in_valid = 1'b0;
      in_cmd   = 2'd3;
      in_addr  = 26'h3FFFFFF;
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (l2_valid !== 1'b1 || l2_cmd !== 2'd1 || l2_addr !== 26'h0ABCDE) begin
            failures++;
            $display("FAIL single_hold[%0d]: got v=%b cmd=%0d addr=%h want v=1 cmd=1 addr=0abcde",
                     c, l2_valid, l2_cmd, l2_addr);
         end
         step();
      end
      l2_ready = 1'b1;
      step();
      l2_ready = 1'b0;
      checks++; if (l2_valid !== 1'b0) begin failures++; $display("FAIL single_pop_valid: got %b want 0", l2_valid); end
      checks++; if (count !== '0) begin failures++; $display("FAIL single_pop_count: got %0d want 0", count); end
      checks++;
      if (obs_out.size() != 1 || obs_out[0] !== {2'd1, 26'h0ABCDE}) begin
         failures++;
         $display("FAIL single_delivered: got %0d msgs want 1 (SENDLINE 0abcde)", obs_out.size());
      end
   endtask

   task automatic test_fill_overflow();
      logic [27:0] w;
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         in_valid = 1'b1;
         in_cmd   = 2'($urandom_range(0, 3));
         in_addr  = 26'(i);
         step();
      end
      in_valid = 1'b0;
      #1;
      checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL fill_count: got %0d want %0d", count, DEPTH); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
      in_valid = 1'b1;
      in_cmd   = 2'd2;
      in_addr  = 26'd9;
      step();
      in_valid = 1'b0;
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow: got %b want 1", overflow); end
      checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL fill_count_after_drop: got %0d want %0d", count, DEPTH); end
      checks++;
      if (l2_addr !== 26'd1 || {l2_cmd, l2_addr} !== mq[0]) begin
         failures++;
         $display("FAIL fill_head_after_drop: got %h want %h", {l2_cmd, l2_addr}, mq[0]);
      end
      l2_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) step();
      l2_ready = 1'b0;
      checks++; if (obs_out.size() != DEPTH) begin failures++; $display("FAIL fill_drain_size: got %0d want %0d", obs_out.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < obs_out.size(); i++) begin
         w = obs_out[i];
         checks++;
         if (w[25:0] !== 26'(i + 1) || w !== exp_out[i]) begin
            failures++;
            $display("FAIL fill_order[%0d]: got %h want addr %0d (%h)", i, w, i + 1, exp_out[i]);
         end
      end
   endtask

   task automatic test_full_push_pop();
      logic [25:0] want[$];
      logic [27:0] w;
      do_reset();
      for (int i = 1; i <= DEPTH; i++) begin
         in_valid = 1'b1; in_cmd = 2'd0; in_addr = 26'(i);
         step();
      end
      l2_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_addr = 26'(100 + i);
         in_cmd  = 2'd3;
         #1;
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpp_in_ready[%0d]: got %b want 1", i, in_ready); end
         step();
         checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL fullpp_count[%0d]: got %0d want %0d", i, count, DEPTH); end
      end
      in_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) step();
      l2_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) want.push_back(26'(i));
      for (int i = 0; i < 3; i++) want.push_back(26'(100 + i));
      checks++; if (obs_out.size() != want.size()) begin failures++; $display("FAIL fullpp_size: got %0d want %0d", obs_out.size(), want.size()); end
      for (int i = 0; i < want.size() && i < obs_out.size(); i++) begin
         w = obs_out[i];
         checks++;
         if (w[25:0] !== want[i]) begin
            failures++;
            $display("FAIL fullpp_order[%0d]: got addr %0d want %0d", i, w[25:0], want[i]);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int c = 0; c < 60; c++) begin
         in_valid = ($urandom_range(0, 9) < 6);
         l2_ready = ($urandom_range(0, 9) < 5);
         in_cmd   = 2'($urandom_range(0, 3));
         in_addr  = 26'($urandom);
         step();
         checks++;
         if (count !== CW'(mq.size()) || l2_valid !== (mq.size() != 0) || overflow !== m_ovf) begin
            failures++;
            $display("FAIL wrap_state[%0d]: got cnt=%0d v=%b ovf=%b want cnt=%0d v=%b ovf=%b",
                     c, count, l2_valid, overflow, mq.size(), mq.size() != 0, m_ovf);
         end
         if (mq.size() != 0) begin
            checks++;
            if ({l2_cmd, l2_addr} !== mq[0]) begin
               failures++;
               $display("FAIL wrap_head[%0d]: got %h want %h", c, {l2_cmd, l2_addr}, mq[0]);
            end
         end
      end
      in_valid = 1'b0;
      l2_ready = 1'b1;
      for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) step();
      l2_ready = 1'b0;
      checks++; if (count !== '0) begin failures++; $display("FAIL wrap_final_count: got %0d want 0", count); end
      checks++; if (obs_out.size() != exp_out.size()) begin failures++; $display("FAIL wrap_total: got %0d want %0d", obs_out.size(), exp_out.size()); end
      for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
         checks++;
         if (obs_out[i] !== exp_out[i]) begin
            failures++;
            $display("FAIL wrap_order[%0d]: got %h want %h", i, obs_out[i], exp_out[i]);
         end
      end
   endtask

   task automatic test_drain();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_cmd = 2'(i); in_addr = 26'(32 + i);
         step();
      end
      in_valid = 1'b0;
      Finish   = 1'b1;
      l2_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (drained !== 1'b0) begin failures++; $display("FAIL drain_early[%0d]: got %b want 0", i, drained); end
      end
      checks++; if (count !== '0) begin failures++; $display("FAIL drain_count: got %0d want 0", count); end
      step();
      checks++; if (drained !== 1'b1) begin failures++; $display("FAIL drain_done: got %b want 1", drained); end
      in_valid = 1'b1; l2_ready = 1'b0; in_addr = 26'd77; in_cmd = 2'd1;
      for (int i = 0; i < 4; i++) begin
         step();
         in_valid = 1'b0;
         l2_ready = 1'b1;
         checks++;
         if (drained !== m_done) begin
            failures++;
            $display("FAIL drain_repush[%0d]: got %b want %b", i, drained, m_done);
         end
      end
      l2_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i <= DEPTH; i++) begin
         in_valid = 1'b1; in_cmd = 2'(i); in_addr = 26'($urandom);
         step();
      end
      in_valid = 1'b0;
      checks++; if (overflow !== m_ovf) begin failures++; $display("FAIL rmid_pre_overflow: got %b want %b", overflow, m_ovf); end
      @(negedge Clock);
      #2;
      clear = 1'b0;
      #1;
      checks++; if (l2_valid !== 1'b0) begin failures++; $display("FAIL rmid_l2_valid: got %b want 0", l2_valid); end
      checks++; if (count !== '0) begin failures++; $display("FAIL rmid_count: got %0d want 0", count); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
      clear = 1'b1;
      model_clear();
      l2_ready = 1'b1;
      @(posedge Clock);
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (l2_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL rmid_after[%0d]: got v=%b cnt=%0d want v=0 cnt=0", i, l2_valid, count);
         end
      end
      l2_ready = 1'b0;
   endtask

   initial begin
      in_valid = 1'b0;
      in_cmd   = 2'd0;
      in_addr  = 26'd0;
      l2_ready = 1'b0;
      Finish   = 1'b0;
      clear    = 1'b1;
      model_clear();
      test_reset();
      test_single();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_drain();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
